comp_result_tally: RTL and testbench

- Downstream stage of the 4-bit magnitude comparator.
- Consumes its per-sample greater/equal/smaller flags (g/e/s) through a valid/ready handshake.
- Tallies each outcome over a window of WINDOW accepted samples, then presents the three counts plus a majority code through a second valid/ready handshake.
- Feeds the results/statistics logic of the comparator test harness.

---
 rtl/comp_result_tally_pkg.sv | 25 ++
 rtl/comp_bin_counter.sv | 20 ++
 rtl/comp_result_tally.sv | 105 ++++++++++
 tb/tb_comp_result_tally.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/comp_result_tally_pkg.sv
// Shared types and constants for the comparator result tally block.
package comp_pkg;

    typedef enum logic {
        COUNT  = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [1:0] MAJ_G = 2'b10;
    localparam logic [1:0] MAJ_S = 2'b01;
    localparam logic [1:0] MAJ_E = 2'b00;

    localparam int WINDOW_DEFAULT = 8;

    // Strictly greatest bin wins; e-greatest and any tie both report MAJ_E.
    function automatic logic [1:0] maj_of(input int ng, input int ne, input int ns);
        if (ng > ne && ng > ns)
            return MAJ_G;
        else if (ns > ng && ns > ne)
            return MAJ_S;
        else
            return MAJ_E;
    endfunction

endpackage

// File: rtl/comp_bin_counter.sv
// Saturation-free up counter with synchronous clear and enable; the caller
// guarantees it never counts past WINDOW.
module comp_bin_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/comp_result_tally.sv
// Tallies comparator g/e/s outcomes over WINDOW samples and reports counts and
// a majority code. Optional one-hot sample checking: COMP_ONEHOT_CHECK_EN.
module comp_result_tally
    import comp_pkg::*;
#(
    parameter  int WINDOW = WINDOW_DEFAULT,
    localparam int CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          g,
    input  logic          e,
    input  logic          s,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt_g,
    output logic [CW-1:0] cnt_e,
    output logic [CW-1:0] cnt_s,
    output logic [CW-1:0] cnt_n,
    output logic [1:0]    out_maj,
    output logic          err
);

    state_t state, state_next;
    logic   accept, legal;
    logic   inc_g, inc_e, inc_s, inc_n;
    logic   full, flush_go, clr, load_maj;
    logic [1:0] maj_next;

    assign in_ready  = (state == COUNT);
    assign out_valid = (state == REPORT);
    assign accept    = in_valid && in_ready;

`ifdef COMP_ONEHOT_CHECK_EN
    assign legal = $onehot({g, e, s});

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (accept && !legal)
            err <= 1'b1;
    end
`else
    assign legal = 1'b1;
    assign err   = 1'b0;
`endif

    // g > e > s priority; an all-zero sample only advances cnt_n.
    assign inc_n = accept && legal;
    assign inc_g = inc_n && g;
    assign inc_e = inc_n && !g && e;
    assign inc_s = inc_n && !g && !e && s;

    assign full     = inc_n && (cnt_n == CW'(WINDOW - 1));
    assign flush_go = flush && ((cnt_n != '0) || inc_n);

    // Majority is judged on the counts as they will stand after this edge.
    assign maj_next = maj_of(int'(cnt_g) + int'(inc_g),
                             int'(cnt_e) + int'(inc_e),
                             int'(cnt_s) + int'(inc_s));

    always_ff @(posedge clk) begin
        if (rst)
            state <= COUNT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_maj   = 1'b0;
        clr        = 1'b0;
        case (state)
            COUNT: begin
                if (full || flush_go) begin
                    state_next = REPORT;
                    load_maj   = 1'b1;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_next = COUNT;
                    clr        = 1'b1;
                end
            end
            default: state_next = COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_maj <= MAJ_E;
        else if (load_maj)
            out_maj <= maj_next;
    end

    comp_bin_counter #(.CW(CW)) u_cnt_g (.clk(clk), .rst(rst), .clr(clr), .en(inc_g), .count(cnt_g));
    comp_bin_counter #(.CW(CW)) u_cnt_e (.clk(clk), .rst(rst), .clr(clr), .en(inc_e), .count(cnt_e));
    comp_bin_counter #(.CW(CW)) u_cnt_s (.clk(clk), .rst(rst), .clr(clr), .en(inc_s), .count(cnt_s));
    comp_bin_counter #(.CW(CW)) u_cnt_n (.clk(clk), .rst(rst), .clr(clr), .en(inc_n), .count(cnt_n));

endmodule

// File: tb/tb_comp_result_tally.sv
// Scoreboard bench for comp_result_tally (WINDOW=8): directed windows, pushes
// hand-computed reports, a negedge monitor pops and compares on each handshake.
module tb_comp_result_tally;

    localparam int CW = 4;

    typedef struct {
        int g;
        int e;
        int s;
        int n;
        int maj;
    } rpt_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          g = 1'b0, e = 1'b0, s = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] cnt_g, cnt_e, cnt_s, cnt_n;
    logic [1:0]    out_maj;
    logic          err;

    int   vecs = 0;
    int   miscompares = 0;
    int   popped = 0;
    rpt_t exp_q[$];

    comp_result_tally #(.WINDOW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .g(g), .e(e), .s(s), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .cnt_g(cnt_g), .cnt_e(cnt_e), .cnt_s(cnt_s),
        .cnt_n(cnt_n), .out_maj(out_maj), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int pg, input int pe, input int ps, input int pn, input int pm);
        rpt_t r;
        r.g = pg; r.e = pe; r.s = ps; r.n = pn; r.maj = pm;
        exp_q.push_back(r);
    endtask

    // Monitor: every accepted report is matched against the queue head.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_report", 1, 0);
            end else begin
                rpt_t r;
                r = exp_q.pop_front();
                popped++;
                chk("rpt_cnt_g", int'(cnt_g), r.g);
                chk("rpt_cnt_e", int'(cnt_e), r.e);
                chk("rpt_cnt_s", int'(cnt_s), r.s);
                chk("rpt_cnt_n", int'(cnt_n), r.n);
                chk("rpt_maj",   int'(out_maj), r.maj);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [2:0] ges, input logic fl);
        wait_ready();
        in_valid = 1'b1;
        {g, e, s} = ges;
        flush = fl;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        {g, e, s} = 3'b000;
    endtask

    initial begin
        int bad;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_cnt_n",     int'(cnt_n), 0);
        chk("rst_maj",       int'(out_maj), 0);
        chk("rst_err",       int'(err), 0);

        // Full window: 3 g, 2 e, 3 s -> tie, maj 00
        out_ready = 1'b1;
        push(3, 2, 3, 8, 0);
        repeat (3) send(3'b100, 1'b0);
        repeat (2) send(3'b010, 1'b0);
        repeat (3) send(3'b001, 1'b0);
        chk("w1_out_valid", int'(out_valid), 1);
        chk("w1_in_ready_low", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("w1_in_ready_back", int'(in_ready), 1);

        // Backpressure: 5 g + 3 s held for 10 cycles
        out_ready = 1'b0;
        push(5, 0, 3, 8, 2);
        repeat (5) send(3'b100, 1'b0);
        repeat (3) send(3'b001, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || in_ready || cnt_g != 4'd5 || cnt_e != 4'd0 || cnt_s != 4'd3 || out_maj != 2'b10)
                bad++;
            @(posedge clk); #1;
        end
        chk("bp_stable_cycles_bad", bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", int'(in_ready), 1);

        // Flush together with a 4th sample
        push(1, 3, 0, 4, 0);
        repeat (3) send(3'b010, 1'b0);
        send(3'b100, 1'b1);
        chk("fl_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        wait_ready();

        // Flush with nothing counted: no report
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl0_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("fl0_out_valid_later", int'(out_valid), 0);
        chk("fl0_in_ready", int'(in_ready), 1);

        // Reset mid-window discards partial data; sample during rst ignored
        repeat (5) send(3'b100, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        {g, e, s} = 3'b100;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        {g, e, s} = 3'b000;
        chk("midrst_cnt_n", int'(cnt_n), 0);
        chk("midrst_cnt_g", int'(cnt_g), 0);
        push(0, 0, 8, 8, 1);
        repeat (8) send(3'b001, 1'b0);
        @(posedge clk); #1;
        wait_ready();

        // Illegal flag patterns inside a g window
`ifdef COMP_ONEHOT_CHECK_EN
        push(8, 0, 0, 8, 2);
        send(3'b100, 1'b0);
        send(3'b100, 1'b0);
        send(3'b110, 1'b0);
        send(3'b100, 1'b0);
        send(3'b000, 1'b0);
        repeat (5) send(3'b100, 1'b0);
        chk("ill_err_set", int'(err), 1);
`else
        push(7, 0, 0, 8, 2);
        send(3'b100, 1'b0);
        send(3'b100, 1'b0);
        send(3'b110, 1'b0);
        send(3'b100, 1'b0);
        send(3'b000, 1'b0);
        repeat (3) send(3'b100, 1'b0);
        chk("ill_err_zero", int'(err), 0);
`endif
        chk("ill_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        wait_ready();
`ifdef COMP_ONEHOT_CHECK_EN
        chk("ill_err_sticky", int'(err), 1);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ill_err_after_rst", int'(err), 0);

        repeat (5) @(posedge clk);
        #1;
        chk("reports_seen", popped, 5);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
